cv32e40p_snn_fire: RTL and testbench

CV32E40P_SNN_FIRE -- requirements
Module: cv32e40p_snn_fire

---
 rtl/cv32e40p_snn_fire.sv | 150 +++++++++++++++
 tb/tb_cv32e40p_snn_fire.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_snn_fire.sv
// Spiking-neuron fire stage: scans a captured membrane cache row by row, streams spike masks and resets fired neurons.
// Optional macro CV32E40P_SNN_FIRE_SOFT_RESET_EN: fired neurons become saturated (mem - threshold) instead of 0.
module cv32e40p_snn_fire #(
    parameter int ROWS = 8,
    parameter int COLS = 16,
    parameter int DW   = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start_i,
    input  logic signed [DW-1:0]                     threshold_i,
    input  logic signed [ROWS-1:0][COLS-1:0][DW-1:0] M_Cache_i,
    output logic                                     busy_o,
    output logic                                     row_valid_o,
    input  logic                                     row_ready_i,
    output logic [$clog2(ROWS)-1:0]                  row_idx_o,
    output logic [COLS-1:0]                          row_spike_o,
    output logic signed [ROWS-1:0][COLS-1:0][DW-1:0] M_Cache_o,
    output logic [$clog2(ROWS*COLS):0]               spike_cnt_o,
    output logic                                     done_o,
    output logic [1:0]                               state_o
);

    localparam int PW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS*COLS) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Row stream handshake: a row transfers when row_valid_o & row_ready_i on a rising
    // edge; while row_ready_i is low, row_valid_o, row_idx_o and row_spike_o hold.

    logic [1:0]                        state_q, state_d;
    logic [PW-1:0]                     ptr_q, ptr_d;
    logic signed [DW-1:0]              thr_q, thr_d;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] mem_q, mem_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic                              row_valid_q, row_valid_d;
    logic [COLS-1:0]                   row_spike;
    logic [CW-1:0]                     row_pop;

`ifdef CV32E40P_SNN_FIRE_SOFT_RESET_EN
    function automatic logic [DW-1:0] soft_value(input logic [DW-1:0] m, input logic [DW-1:0] t);
        logic signed [DW:0] diff;
        diff = $signed({m[DW-1], m}) - $signed({t[DW-1], t});
        if (diff[DW] != diff[DW-1]) begin
            soft_value = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            soft_value = diff[DW-1:0];
        end
    endfunction
`endif

    // Spike mask is gated by valid so idle/reset never shows 0 >= 0 as a spike.
    always_comb begin
        row_spike = '0;
        if (row_valid_q) begin
            for (int c = 0; c < COLS; c++) begin
                if ($signed(mem_q[ptr_q][c]) >= thr_q) begin
                    row_spike[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        row_pop = '0;
        for (int c = 0; c < COLS; c++) begin
            row_pop = row_pop + CW'(row_spike[c]);
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        thr_d       = thr_q;
        mem_d       = mem_q;
        cnt_d       = cnt_q;
        row_valid_d = row_valid_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mem_d       = M_Cache_i;
                    thr_d       = threshold_i;
                    cnt_d       = '0;
                    ptr_d       = '0;
                    row_valid_d = 1'b1;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (row_ready_i) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (row_spike[c]) begin
`ifdef CV32E40P_SNN_FIRE_SOFT_RESET_EN
                            mem_d[ptr_q][c] = soft_value(mem_q[ptr_q][c], thr_q);
`else
                            mem_d[ptr_q][c] = '0;
`endif
                        end
                    end
                    cnt_d = cnt_q + row_pop;
                    // The last row leaves ptr on ROWS-1 so row_idx_o keeps the final row in IDLE.
                    if (ptr_q == PW'(ROWS - 1)) begin
                        row_valid_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                row_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            thr_q       <= '0;
            mem_q       <= '0;
            cnt_q       <= '0;
            row_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            thr_q       <= thr_d;
            mem_q       <= mem_d;
            cnt_q       <= cnt_d;
            row_valid_q <= row_valid_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign row_valid_o = row_valid_q;
    assign row_idx_o   = ptr_q;
    assign row_spike_o = row_spike;
    assign M_Cache_o   = mem_q;
    assign spike_cnt_o = cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_cv32e40p_snn_fire.sv
// Randomised bench for cv32e40p_snn_fire against a per-cycle behavioural model of the fire scan.
module tb_cv32e40p_snn_fire;

    localparam int ROWS = 8;
    localparam int COLS = 16;
    localparam int DW   = 16;
    localparam int PW   = $clog2(ROWS);
    localparam int CW   = $clog2(ROWS*COLS) + 1;
    localparam int MAXV = (1 << (DW-1)) - 1;
    localparam int MINV = -(1 << (DW-1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                                     start_i;
    logic signed [DW-1:0]                     threshold_i;
    logic signed [ROWS-1:0][COLS-1:0][DW-1:0] m_cache_i;
    logic                                     busy_o;
    logic                                     row_valid_o;
    logic                                     row_ready_i;
    logic [PW-1:0]                            row_idx_o;
    logic [COLS-1:0]                          row_spike_o;
    logic signed [ROWS-1:0][COLS-1:0][DW-1:0] m_cache_o;
    logic [CW-1:0]                            spike_cnt_o;
    logic                                     done_o;
    logic [1:0]                               state_o;

    cv32e40p_snn_fire #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .threshold_i (threshold_i),
        .M_Cache_i   (m_cache_i),
        .busy_o      (busy_o),
        .row_valid_o (row_valid_o),
        .row_ready_i (row_ready_i),
        .row_idx_o   (row_idx_o),
        .row_spike_o (row_spike_o),
        .M_Cache_o   (m_cache_o),
        .spike_cnt_o (spike_cnt_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_mem [ROWS][COLS];
    int              m_thr;
    int              m_phase;   // 0 idle, 1 streaming rows, 2 completion cycle
    int              m_ptr;
    int              m_cnt;
    logic [COLS-1:0] exp_q[$];
    logic [COLS-1:0] row3_spk;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] exp_mem;

    function automatic int fired_value(input int m, input int t);
`ifdef CV32E40P_SNN_FIRE_SOFT_RESET_EN
        int d;
        d = m - t;
        if (d > MAXV) d = MAXV;
        if (d < MINV) d = MINV;
        return d;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_mem[r][c] = 0;
        m_thr   = 0;
        m_phase = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    initial model_reset();

    // ---------------- scoreboard: one compare per output per cycle ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            check("rst_idx", 64'(row_idx_o), 64'd0);
            check("rst_spike", 64'(row_spike_o), 64'd0);
        end
        check("busy", 64'(busy_o), 64'(m_phase != 0));
        check("valid", 64'(row_valid_o), 64'(m_phase == 1));
        check("done", 64'(done_o), 64'(m_phase == 2));
        check("spike_cnt", 64'(spike_cnt_o), 64'(m_cnt));
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_mem[r][c] = DW'(m_mem[r][c]);
        n_checks++;
        if (m_cache_o !== exp_mem) begin
            n_errors++;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (m_cache_o[r][c] !== exp_mem[r][c])
                        $display("FAIL mcache[%0d][%0d]: got %0d expected %0d at %0t",
                                 r, c, $signed(m_cache_o[r][c]), $signed(exp_mem[r][c]), $time);
        end
        if (m_phase == 1) begin
            check("row_idx", 64'(row_idx_o), 64'(m_ptr));
            if (exp_q.size() == 0) check("row_spike_q_empty", 64'(row_spike_o), 64'hdead);
            else check("row_spike", 64'(row_spike_o), 64'(exp_q[0]));
        end

        if (rst_n) begin
            case (m_phase)
                0: if (start_i) begin
                    m_thr = int'(threshold_i);
                    for (int r = 0; r < ROWS; r++) begin
                        logic [COLS-1:0] spk;
                        spk = '0;
                        for (int c = 0; c < COLS; c++) begin
                            m_mem[r][c] = int'($signed(m_cache_i[r][c]));
                            if (m_mem[r][c] >= m_thr) spk[c] = 1'b1;
                        end
                        exp_q.push_back(spk);
                    end
                    m_cnt   = 0;
                    m_ptr   = 0;
                    m_phase = 1;
                end
                1: if (row_ready_i) begin
                    logic [COLS-1:0] spk;
                    spk = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                    if (m_ptr == 3) row3_spk = row_spike_o;
                    for (int c = 0; c < COLS; c++)
                        if (spk[c]) m_mem[m_ptr][c] = fired_value(m_mem[m_ptr][c], m_thr);
                    m_cnt = m_cnt + $countones(spk);
                    if (m_ptr == ROWS - 1) m_phase = 2;
                    else m_ptr++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_fill(input int thr, input int val);
        threshold_i = DW'(thr);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_cache_i[r][c] = DW'(val);
    endtask

    task automatic load_random(input int thr);
        int v;
        threshold_i = DW'(thr);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                case ($urandom_range(0, 3))
                    0: v = thr;
                    1: v = thr - 1;
                    default: v = int'($urandom_range(0, 65535)) - 32768;
                endcase
                m_cache_i[r][c] = DW'(v);
            end
    endtask

    task automatic run_scan(input int rdy_mode, input int stall_row, input int stall_len,
                            input bit start_in_stall, input bit start_at_done, output int lat);
        int  stalled;
        bit  seen_done;
        stalled   = 0;
        seen_done = 0;
        @(posedge clk); #2;
        start_i     = 1'b1;
        row_ready_i = 1'b1;
        lat         = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); lat++; #1;
            if (done_o) begin
                seen_done = 1;
                break;
            end
            #1;
            start_i = 1'b0;
            if (row_valid_o && int'(row_idx_o) == stall_row && stalled < stall_len) begin
                row_ready_i = 1'b0;
                stalled++;
                if (start_in_stall && stalled == 3) start_i = 1'b1;
            end else if (rdy_mode == 1) begin
                row_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                row_ready_i = 1'b1;
            end
        end
        if (!seen_done) check("scan_timeout", 64'd0, 64'd1);
        #1;
        start_i = start_at_done;
        @(posedge clk); #2;
        start_i     = 1'b0;
        row_ready_i = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ok;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        row_ready_i = 1'b1;
        load_fill(0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("init_cnt", 64'(spike_cnt_o), 64'd0);
        check("init_busy", 64'(busy_o), 64'd0);

        // all below threshold
        load_fill(100, 50);
        run_scan(0, -1, 0, 0, 0, lat);
        check("lat_nostall", 64'(lat), 64'(ROWS + 1));
        check("below_cnt", 64'(spike_cnt_o), 64'd0);
        ok = 1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_cache_o[r][c] !== 16'sd50) ok = 0;
        check("below_unchanged", 64'(ok), 64'd1);

        // equality fires, one below does not; start in done cycle ignored
        load_fill(100, 0);
        m_cache_i[3][5] = 16'sd100;
        m_cache_i[3][6] = 16'sd99;
        run_scan(0, -1, 0, 0, 1, lat);
        check("eq_row3_spike", 64'(row3_spk), 64'h0020);
        check("eq_cnt", 64'(spike_cnt_o), 64'd1);
        check("eq_m35", 64'(m_cache_o[3][5]), 64'd0);
        check("eq_m36", 64'(m_cache_o[3][6]), 64'd99);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("done_start_ignored", 64'(busy_o), 64'd0);
        check("idle_hold_cnt", 64'(spike_cnt_o), 64'd1);

        // stall at row 2 for 5 cycles with a start pulse during the stall
        run_scan(0, 2, 5, 1, 0, lat);
        check("lat_stall", 64'(lat), 64'(ROWS + 6));

        // fire value: small positive
        load_fill(10, 0);
        m_cache_i[0][0] = 16'sd25;
`ifdef CV32E40P_SNN_FIRE_SOFT_RESET_EN
        run_scan(0, -1, 0, 0, 0, lat);
        check("fire_m00", 64'(m_cache_o[0][0]), 64'd15);
`else
        run_scan(0, -1, 0, 0, 0, lat);
        check("fire_m00", 64'(m_cache_o[0][0]), 64'd0);
`endif
        check("fire_cnt", 64'(spike_cnt_o), 64'd1);

        // saturation corner: lowest threshold, highest membrane
        load_fill(MINV, MAXV);
        run_scan(0, -1, 0, 0, 0, lat);
        check("sat_cnt", 64'(spike_cnt_o), 64'(ROWS * COLS));
`ifdef CV32E40P_SNN_FIRE_SOFT_RESET_EN
        check("sat_m77", 64'(m_cache_o[7][7]), 64'h7fff);
`else
        check("sat_m77", 64'(m_cache_o[7][7]), 64'd0);
`endif

        // asynchronous reset mid-scan at row 4
        load_fill(100, 0);
        m_cache_i[3][5] = 16'sd100;
        m_cache_i[3][6] = 16'sd99;
        @(posedge clk); #2;
        start_i     = 1'b1;
        row_ready_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (row_valid_o && row_idx_o == PW'(4)) begin
                ok = 1;
                break;
            end
        end
        check("reach_row4", 64'(ok), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_busy", 64'(busy_o), 64'd0);
        check("async_cnt", 64'(spike_cnt_o), 64'd0);
        check("async_mem", 64'(m_cache_o == '0), 64'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_scan(0, -1, 0, 0, 0, lat);
        check("post_rst_lat", 64'(lat), 64'(ROWS + 1));
        check("post_rst_cnt", 64'(spike_cnt_o), 64'd1);

        // randomized scans with random back-pressure
        for (int k = 0; k < 12; k++) begin
            load_random(int'($urandom_range(0, 65535)) - 32768);
            run_scan(1, int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, 4)),
                     $urandom_range(0, 1), $urandom_range(0, 1), lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
